// File: rtl/display_mux_driver.sv
// ---------------------------------------------------------------------------
// display_mux_driver
//
// Time-multiplexed driver for a 4-digit common-anode seven-segment display.
// Digits are scanned one slot at a time. Each slot of DIV cycles opens with
// BLANK all-off cycles so that segment and anode changes never overlap
// (anti-ghosting). The four PIO patterns are captured once per frame, in the
// first frame cycle, so a PIO write in mid-frame cannot tear the picture.
//
// Optional feature macro: DISPLAY_MUX_BLINK_EN
//   When defined, digits selected by blink_mask go dark on alternate
//   BLINK_FRAMES-frame half-periods. When undefined, the blink registers are
//   not built and blink_mask is ignored.
//
// Parameters:
//   DIV          clock cycles per digit slot (DIV >= BLANK + 1)
//   BLANK        leading off-cycles per slot (BLANK >= 1)
//   BLINK_FRAMES frames per blink half-period (BLINK_FRAMES >= 1)
//
// Ports:
//   clk         system clock
//   reset_n     asynchronous active-low reset
//   enable      scan enable; low holds the scan at its start and blanks
//   seg0_in..3  active-high segment patterns (bit 0 = a ... bit 6 = g)
//   blink_mask  bit i set = digit i blinks
//   seg_n       registered active-low segment drive
//   dig_n       registered active-low anode select, bit i = digit i
// ---------------------------------------------------------------------------
module display_mux_driver #(
    parameter int DIV          = 50000,
    parameter int BLANK        = 500,
    parameter int BLINK_FRAMES = 64
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       enable,
    input  logic [6:0] seg0_in,
    input  logic [6:0] seg1_in,
    input  logic [6:0] seg2_in,
    input  logic [6:0] seg3_in,
    input  logic [3:0] blink_mask,
    output logic [6:0] seg_n,
    output logic [3:0] dig_n
);

    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

    localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(DIV - 1);
    localparam logic [CNT_W-1:0] BLANK_END = CNT_W'(BLANK);

    typedef enum logic {
        SLOT_BLANK = 1'b0,
        SLOT_DRIVE = 1'b1
    } slot_t;

    logic [CNT_W-1:0] cnt_r;
    logic [1:0]       digit_r;
    logic [6:0]       snap_r [4];
    logic [6:0]       seg_n_r;
    logic [3:0]       dig_n_r;

    logic [CNT_W-1:0] cnt_nxt_s;
    logic [1:0]       digit_nxt_s;
    logic [6:0]       snap_nxt_s [4];
    logic             frame_start_s;
    logic             frame_wrap_s;
    slot_t            slot_nxt_s;
    logic             hide_s;
    logic [6:0]       seg_nxt_s;
    logic [3:0]       dig_nxt_s;

    assign frame_start_s = enable && (digit_r == 2'd0) && (cnt_r == {CNT_W{1'b0}});
    assign frame_wrap_s  = enable && (digit_r == 2'd3) && (cnt_r == CNT_MAX);

    // Scan counter, digit index and per-frame pattern snapshot next state
    always_comb begin
        cnt_nxt_s   = cnt_r;
        digit_nxt_s = digit_r;
        for (int i = 0; i < 4; i++) begin
            snap_nxt_s[i] = snap_r[i];
        end
        if (!enable) begin
            cnt_nxt_s   = {CNT_W{1'b0}};
            digit_nxt_s = 2'd0;
        end else begin
            if (cnt_r == CNT_MAX) begin
                cnt_nxt_s   = {CNT_W{1'b0}};
                digit_nxt_s = digit_r + 2'd1;
            end else begin
                cnt_nxt_s   = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end
            if (frame_start_s) begin
                snap_nxt_s[0] = seg0_in;
                snap_nxt_s[1] = seg1_in;
                snap_nxt_s[2] = seg2_in;
                snap_nxt_s[3] = seg3_in;
            end else begin
                snap_nxt_s[0] = snap_r[0];
            end
        end
    end

`ifdef DISPLAY_MUX_BLINK_EN
    localparam int BC_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [BC_W-1:0] BC_MAX = BC_W'(BLINK_FRAMES - 1);

    logic [BC_W-1:0] blink_cnt_r;
    logic            blink_off_r;
    logic [BC_W-1:0] blink_cnt_nxt_s;
    logic            blink_off_nxt_s;

    // Blink half-period counter: one step per frame wrap, toggles on wrap
    always_comb begin
        blink_cnt_nxt_s = blink_cnt_r;
        blink_off_nxt_s = blink_off_r;
        if (!enable) begin
            blink_cnt_nxt_s = {BC_W{1'b0}};
            blink_off_nxt_s = 1'b0;
        end else if (frame_wrap_s) begin
            if (blink_cnt_r == BC_MAX) begin
                blink_cnt_nxt_s = {BC_W{1'b0}};
                blink_off_nxt_s = ~blink_off_r;
            end else begin
                blink_cnt_nxt_s = blink_cnt_r + {{(BC_W-1){1'b0}}, 1'b1};
            end
        end else begin
            blink_cnt_nxt_s = blink_cnt_r;
        end
    end

    // Blink state registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            blink_cnt_r <= {BC_W{1'b0}};
            blink_off_r <= 1'b0;
        end else begin
            blink_cnt_r <= blink_cnt_nxt_s;
            blink_off_r <= blink_off_nxt_s;
        end
    end

    assign hide_s = blink_off_nxt_s && blink_mask[digit_nxt_s];
`else
    logic blink_unused_s;
    assign blink_unused_s = ^{blink_mask, 1'(BLINK_FRAMES % 2), frame_wrap_s};
    assign hide_s         = 1'b0;
`endif

    // Slot phase is a pure function of the position inside the slot
    assign slot_nxt_s = (cnt_nxt_s < BLANK_END) ? SLOT_BLANK : SLOT_DRIVE;

    // Output decode of the next state, so outputs line up with cnt without lag
    always_comb begin
        seg_nxt_s = 7'h7F;
        dig_nxt_s = 4'hF;
        if (enable && (slot_nxt_s == SLOT_DRIVE) && !hide_s) begin
            seg_nxt_s = ~snap_nxt_s[digit_nxt_s];
            case (digit_nxt_s)
                2'd0:    dig_nxt_s = 4'b1110;
                2'd1:    dig_nxt_s = 4'b1101;
                2'd2:    dig_nxt_s = 4'b1011;
                2'd3:    dig_nxt_s = 4'b0111;
                default: dig_nxt_s = 4'hF;
            endcase
        end else begin
            seg_nxt_s = 7'h7F;
            dig_nxt_s = 4'hF;
        end
    end

    // Scan state, snapshot and registered display outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_r   <= {CNT_W{1'b0}};
            digit_r <= 2'd0;
            for (int i = 0; i < 4; i++) begin
                snap_r[i] <= 7'h00;
            end
            seg_n_r <= 7'h7F;
            dig_n_r <= 4'hF;
        end else begin
            cnt_r   <= cnt_nxt_s;
            digit_r <= digit_nxt_s;
            for (int i = 0; i < 4; i++) begin
                snap_r[i] <= snap_nxt_s[i];
            end
            seg_n_r <= seg_nxt_s;
            dig_n_r <= dig_nxt_s;
        end
    end

    assign seg_n = seg_n_r;
    assign dig_n = dig_n_r;

endmodule

// File: tb/tb_display_mux_driver.sv
// ---------------------------------------------------------------------------
// tb_display_mux_driver
//
// Self-checking bench for display_mux_driver with DIV=8, BLANK=2,
// BLINK_FRAMES=2. A directed opening (basic scan, tear-free update, snapshot
// edge, enable drop) is followed by randomized pattern, enable, mask and
// asynchronous reset activity. Expected outputs come from a frame-time model:
// the time since the scan (re)started selects slot, digit and phase by plain
// division; the displayed patterns are those present at the frame's first
// cycle. Honours DISPLAY_MUX_BLINK_EN in the same way as the design.
// ---------------------------------------------------------------------------
module tb_display_mux_driver;

    localparam int DIV          = 8;
    localparam int BLANK        = 2;
    localparam int BLINK_FRAMES = 2;
    localparam int FRAME        = 4 * DIV;
    localparam int N_CYC        = 1800;

    logic       clk;
    logic       reset_n;
    logic       enable;
    logic [6:0] seg_in [4];
    logic [3:0] blink_mask;
    logic [6:0] seg_n;
    logic [3:0] dig_n;

    display_mux_driver #(
        .DIV          (DIV),
        .BLANK        (BLANK),
        .BLINK_FRAMES (BLINK_FRAMES)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .enable     (enable),
        .seg0_in    (seg_in[0]),
        .seg1_in    (seg_in[1]),
        .seg2_in    (seg_in[2]),
        .seg3_in    (seg_in[3]),
        .blink_mask (blink_mask),
        .seg_n      (seg_n),
        .dig_n      (dig_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    // Reference model state
    int         t;          // cycles since the scan last (re)started
    logic [6:0] snap_m [4]; // patterns shown in the current frame
    int         off_run;
    logic [3:0] last_lit;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0d, time %0t)", tag, obs, exp, t, $time);
        end
    endtask

    task automatic check_outputs();
        int         pos;
        int         d;
        int         frame;
        int         zeros;
        logic       lit;
        logic [3:0] exp_dig;
        logic [6:0] exp_seg;
        pos   = t % DIV;
        d     = (t / DIV) % 4;
        frame = t / FRAME;
        lit   = (pos >= BLANK);
`ifdef DISPLAY_MUX_BLINK_EN
        if (((frame / BLINK_FRAMES) % 2) == 1 && blink_mask[d]) lit = 1'b0;
`else
        if (frame < 0) lit = 1'b0;
`endif
        exp_dig = lit ? ~(4'b0001 << d) : 4'hF;
        exp_seg = lit ? ~snap_m[d] : 7'h7F;
        check("dig_n", 32'(dig_n), 32'(exp_dig));
        check("seg_n", 32'(seg_n), 32'(exp_seg));
        // independent structural checks on the observed anode drive
        zeros = 0;
        for (int i = 0; i < 4; i++) if (dig_n[i] == 1'b0) zeros++;
        check("onecold", 32'(zeros <= 1), 32'd1);
        if (dig_n != 4'hF) begin
            if (last_lit != 4'hF && dig_n != last_lit)
                check("blank_gap", 32'(off_run >= BLANK), 32'd1);
            last_lit = dig_n;
            off_run  = 0;
        end else begin
            off_run++;
        end
    endtask

    task automatic model_step();
        if (enable && (t % FRAME) == 0)
            for (int i = 0; i < 4; i++) snap_m[i] = seg_in[i];
        t = enable ? t + 1 : 0;
    endtask

    task automatic model_reset();
        t = 0;
        for (int i = 0; i < 4; i++) snap_m[i] = 7'h00;
    endtask

    initial begin
        reset_n    = 1'b0;
        enable     = 1'b1;
        seg_in[0]  = 7'h3F;
        seg_in[1]  = 7'h06;
        seg_in[2]  = 7'h5B;
        seg_in[3]  = 7'h4F;
        blink_mask = 4'b0010;
        off_run    = 0;
        last_lit   = 4'hF;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("reset_seg", 32'(seg_n), 32'h7F);
        check("reset_dig", 32'(dig_n), 32'hF);
        reset_n = 1'b1;

        for (int cyc = 0; cyc < N_CYC; cyc++) begin
            check_outputs();
            // stimulus for this cycle
            if (cyc == 5)  seg_in[1] = 7'h7F;
            if (cyc == 32) seg_in[0] = 7'h06;
            if (cyc == 76) enable = 1'b0;
            if (cyc == 90) enable = 1'b1;
            if (cyc >= 120) begin
                if (enable && $urandom_range(0, 199) == 0) enable = 1'b0;
                else if (!enable && $urandom_range(0, 9) == 0) enable = 1'b1;
                for (int i = 0; i < 4; i++)
                    if ($urandom_range(0, 9) == 0) seg_in[i] = 7'($urandom);
                if ((t % DIV) == 0 && $urandom_range(0, 3) == 0)
                    blink_mask = 4'($urandom);
            end
            model_step();
            if (cyc == 140 || (cyc > 200 && (cyc % 397) == 0)) begin
                #3;
                reset_n = 1'b0;
                #1;
                check("async_rst_seg", 32'(seg_n), 32'h7F);
                check("async_rst_dig", 32'(dig_n), 32'hF);
                @(posedge clk);
                #1;
                @(posedge clk);
                #1;
                reset_n  = 1'b1;
                model_reset();
                off_run  = 0;
                last_lit = 4'hF;
            end else begin
                @(posedge clk);
                #1;
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
